mul_div_control: RTL



---
 rtl/mul_div_control.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mul_div_control.sv
// Fetch/execute control for ALU and mul/div instructions.
// Strobes are decoded from the state register and the live IR fields.
module mul_div_control (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic        PCin,
   output logic        PCout,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zlowin,
   output logic        Zhighin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIin,
   output logic        LOin,
   output logic        IncPC,
   output logic        Read,
   output logic [3:0]  ALUop,
   output logic        busy,
   output logic        done,
   output logic        illegal
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_ILL
   } state_t;

   state_t state_q, state_d;
   logic   first_q, first_d;

   logic [4:0]  opcode;
   logic [3:0]  ra, rb, rc;
   logic        hilo, legal;
   logic [15:0] ra_oh, rb_oh, rc_oh;
   logic        unused_ir;

   assign opcode    = ir[31:27];
   assign ra        = ir[26:23];
   assign rb        = ir[22:19];
   assign rc        = ir[18:15];
   assign unused_ir = ^ir[14:0];
   assign hilo      = (opcode == 5'd11) || (opcode == 5'd12);
   assign legal     = (opcode <= 5'd12);
   assign ra_oh     = 16'(1) << ra;
   assign rb_oh     = 16'(1) << rb;
   assign rc_oh     = 16'(1) << rc;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_T0;
         S_T0:    state_d = S_T1;
         S_T1:    if (mem_ready) state_d = S_T2;
         S_T2:    state_d = legal ? S_T3 : S_ILL;
         S_T3:    state_d = S_T4;
         S_T4:    state_d = S_T5;
         S_T5:    state_d = hilo ? S_T6 : S_IDLE;
         S_T6:    state_d = S_IDLE;
         S_ILL:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // re-armed on every entry to T1
      first_d = (state_q == S_T0);
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      Rin      = '0;
      Rout     = '0;
      PCin     = 1'b0;
      PCout    = 1'b0;
      MARin    = 1'b0;
      MDRin    = 1'b0;
      MDRout   = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      Zlowin   = 1'b0;
      Zhighin  = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      ALUop    = '0;
      done     = 1'b0;
      illegal  = 1'b0;
      busy     = (state_q != S_IDLE);
      unique case (state_q)
         S_T0: begin
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            Zlowin = 1'b1;
         end
         S_T1: begin
            Read    = 1'b1;
            MDRin   = 1'b1;
            Zlowout = first_q;
            PCin    = first_q;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            Rout = hilo ? ra_oh : rb_oh;
            Yin  = 1'b1;
         end
         S_T4: begin
            Rout    = hilo ? rb_oh : rc_oh;
            ALUop   = opcode[3:0];
            Zlowin  = 1'b1;
            Zhighin = hilo;
         end
         S_T5: begin
            Zlowout = 1'b1;
            LOin    = hilo;
            Rin     = hilo ? 16'd0 : ra_oh;
            done    = !hilo;
         end
         S_T6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
            done     = 1'b1;
         end
         S_ILL: begin
            illegal = 1'b1;
            done    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
